// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters for the integer register
// file. Gates issue on RAW hazards against in-flight writes and on a register
// reaching its outstanding-write limit. Writeback retires pending writes.
// Build option: define REG_SCOREBOARD_BYPASS_EN to let a source whose final
// pending write is completing this cycle issue alongside that writeback (the
// issue stage then forwards the writeback data).
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [AW-1:0]    issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [AW-1:0]    issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_rd_we,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic             hazard_rs1,
  output logic             hazard_rs2,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0][CNT_W-1:0] cnt_next;
  logic [NREGS-1:0]            busy_next;
  logic                        raw_rs1;
  logic                        raw_rs2;
  logic                        mask_rs1;
  logic                        mask_rs2;
  logic                        full_rd;
  logic                        fire;
  logic                        wb_live;
  logic                        underflow_set;

  // Hazard detection and issue handshake, all from current counter state.
  always_comb begin
    raw_rs1 = issue_valid & issue_rs1_used & (issue_rs1 != '0) & (cnt[issue_rs1] != '0);
    raw_rs2 = issue_valid & issue_rs2_used & (issue_rs2 != '0) & (cnt[issue_rs2] != '0);
`ifdef REG_SCOREBOARD_BYPASS_EN
    mask_rs1 = wb_valid & (wb_rd == issue_rs1) & (cnt[issue_rs1] == CNT_ONE);
    mask_rs2 = wb_valid & (wb_rd == issue_rs2) & (cnt[issue_rs2] == CNT_ONE);
`else
    mask_rs1 = 1'b0;
    mask_rs2 = 1'b0;
`endif
    hazard_rs1  = raw_rs1 & ~mask_rs1;
    hazard_rs2  = raw_rs2 & ~mask_rs2;
    full_rd     = issue_rd_we & (issue_rd != '0) & (cnt[issue_rd] == CNT_MAX);
    issue_ready = ~flush & ~hazard_rs1 & ~hazard_rs2 & ~full_rd;
    fire        = issue_valid & issue_ready;
  end

  // Next-state counters: increment on fire, decrement on writeback, cancel when both.
  always_comb begin
    cnt_next      = cnt;
    busy_next     = '0;
    wb_live       = wb_valid & (wb_rd != '0) & ~flush;
    underflow_set = wb_live & (cnt[wb_rd] == '0);
    for (int i = 0; i < NREGS; i++) begin
      logic inc;
      logic dec;
      inc = fire & issue_rd_we & (issue_rd == AW'(i));
      dec = wb_live & (wb_rd == AW'(i)) & (cnt[i] != '0);
      if (i == 0 || flush) begin
        cnt_next[i] = '0;
      end else if (inc && !dec) begin
        cnt_next[i] = cnt[i] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_next[i] = cnt[i] - CNT_ONE;
      end
      busy_next[i] = (cnt_next[i] != '0);
    end
  end

  // Counter, busy vector and sticky underflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      busy_vec      <= '0;
      err_underflow <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      busy_vec <= busy_next;
      if (underflow_set) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic        issue_rs1_used;
  logic [4:0]  issue_rs2;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_vec;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic we,
                     input logic wbv, input logic [4:0] wbrd, input logic fl,
                     input logic e_rdy, input logic e_h1, input logic e_h2,
                     input logic [31:0] e_busy, input logic e_err);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.we = we; t.wbv = wbv; t.wbrd = wbrd; t.fl = fl;
    t.e_rdy = e_rdy; t.e_h1 = e_h1; t.e_h2 = e_h2; t.e_busy = e_busy; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
    issue_rd = 0; issue_rd_we = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  localparam logic [31:0] B4 = 32'h1 << 4, B5 = 32'h1 << 5, B7 = 32'h1 << 7,
                          B8 = 32'h1 << 8, B9 = 32'h1 << 9, B10 = 32'h1 << 10,
                          B11 = 32'h1 << 11;

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // Columns: v rs1 u1 rs2 u2 rd we | wbv wbrd fl | rdy h1 h2 busy(pre-edge) err
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, 0, 0);                 // 0 idle after reset
    add(1, 0,0, 0,0, 5,1, 0,0,0, 1,0,0, 0, 0);                 // 1 issue rd=5
    add(1, 5,1, 0,0, 0,0, 0,0,0, 0,1,0, B5, 0);                // 2 RAW on rs1=5
    add(1, 5,1, 0,0, 0,0, 1,5,0, BYP,!BYP,0, B5, 0);           // 3 final wb of x5
    add(1, 5,1, 0,0, 0,0, 0,0,0, 1,0,0, 0, 0);                 // 4 hazard gone
    add(1, 0,0, 0,0, 7,1, 0,0,0, 1,0,0, 0, 0);                 // 5 rd=7 #1
    add(1, 0,0, 0,0, 7,1, 0,0,0, 1,0,0, B7, 0);                // 6 rd=7 #2
    add(1, 0,0, 0,0, 7,1, 0,0,0, 1,0,0, B7, 0);                // 7 rd=7 #3
    add(1, 0,0, 0,0, 7,1, 0,0,0, 0,0,0, B7, 0);                // 8 saturated
    add(1, 0,0, 0,0, 7,1, 1,7,0, 0,0,0, B7, 0);                // 9 wb frees one slot next cycle
    add(1, 0,0, 0,0, 7,1, 0,0,0, 1,0,0, B7, 0);                // 10 ready again, fires
    add(1, 0,1, 7,1, 0,0, 0,0,0, 0,0,1, B7, 0);                // 11 RAW on rs2, x0 rs1
    add(1, 0,0, 0,0, 9,1, 0,0,0, 1,0,0, B7, 0);                // 12 cnt9=1
    add(1, 0,0, 0,0, 9,1, 1,9,0, 1,0,0, B7|B9, 0);             // 13 fire+wb same rd
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, B7|B9, 0);             // 14 x9 still busy
    add(0, 0,0, 0,0, 0,0, 1,9,0, 1,0,0, B7|B9, 0);             // 15 retire x9
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, B7, 0);                // 16 cnt9 was exactly 1
    add(1, 0,1, 0,1, 0,1, 0,0,0, 1,0,0, B7, 0);                // 17 all-x0 instruction
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, B7, 0);                // 18 x0 not tracked
    add(0, 0,0, 0,0, 0,0, 1,3,0, 1,0,0, B7, 0);                // 19 wb x3 with cnt=0
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, B7, 1);                // 20 err set
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, B7, 1);                // 21 err sticky
    add(1, 0,0, 0,0, 4,1, 0,0,0, 1,0,0, B7, 1);                // 22 rd=4 #1
    add(1, 0,0, 0,0, 4,1, 0,0,0, 1,0,0, B7|B4, 1);             // 23 rd=4 #2
    add(1, 0,0, 0,0, 8,1, 0,0,0, 1,0,0, B7|B4, 1);             // 24 rd=8
    add(1, 4,1, 0,0,10,1, 1,7,1, 0,1,0, B7|B4|B8, 1);          // 25 flush, wb discarded
    add(1, 4,1, 0,0,10,1, 0,0,0, 1,0,0, 0, 1);                 // 26 pending issue fires
    add(0, 0,0, 0,0, 0,0, 0,0,0, 1,0,0, B10, 1);               // 27 only x10 busy
    add(1, 0,0, 0,0,11,1, 0,0,0, 1,0,0, B10, 1);               // 28 rd=11 #1
    add(1, 0,0, 0,0,11,1, 0,0,0, 1,0,0, B10|B11, 1);           // 29 rd=11 #2
    add(1,11,1, 0,0, 0,0, 1,11,0, 0,1,0, B10|B11, 1);          // 30 wb with cnt=2: no bypass
    add(1,11,1, 0,0, 0,0, 1,11,0, BYP,!BYP,0, B10|B11, 1);     // 31 final wb of x11
    add(1,11,1, 0,0, 0,0, 0,0,0, 1,0,0, B10, 1);               // 32 clear

    repeat (2) @(negedge clk);
    chk("reset_busy", busy_vec, 0);
    chk("reset_err", {31'b0, err_underflow}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      issue_valid = vecs[i].v; issue_rs1 = vecs[i].rs1; issue_rs1_used = vecs[i].u1;
      issue_rs2 = vecs[i].rs2; issue_rs2_used = vecs[i].u2;
      issue_rd = vecs[i].rd; issue_rd_we = vecs[i].we;
      wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_ready", i), {31'b0, issue_ready}, {31'b0, vecs[i].e_rdy});
      chk($sformatf("v%0d_h1", i), {31'b0, hazard_rs1}, {31'b0, vecs[i].e_h1});
      chk($sformatf("v%0d_h2", i), {31'b0, hazard_rs2}, {31'b0, vecs[i].e_h2});
      chk($sformatf("v%0d_busy", i), busy_vec, vecs[i].e_busy);
      chk($sformatf("v%0d_err", i), {31'b0, err_underflow}, {31'b0, vecs[i].e_err});
    end

    // Asynchronous reset in the middle of a cycle with cnt[5]=2.
    @(negedge clk); drive_idle(); issue_valid = 1; issue_rd = 5; issue_rd_we = 1;
    @(negedge clk);
    @(negedge clk); drive_idle();
    #1;
    chk("pre_reset_busy", busy_vec, B10 | B5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy_vec, 0);
    chk("async_reset_err", {31'b0, err_underflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
    #1;
    chk("post_reset_ready", {31'b0, issue_ready}, 1);
    chk("post_reset_h1", {31'b0, hazard_rs1}, 0);
    @(negedge clk); drive_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
